// File: rtl/rvfi_monitor_pkg.sv
// Shared types for the RVFI retirement monitor: FSM states, check codes and
// the sticky error-context record.
package rvfi_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2,
    ERROR  = 2'd3
  } MonState;

  typedef enum logic [2:0] {
    NONE       = 3'd0,
    E_ORDER    = 3'd1,
    E_PC       = 3'd2,
    E_X0       = 3'd3,
    E_ALIGN    = 3'd4,
    E_MODE     = 3'd5,
    E_POSTHALT = 3'd6
  } ErrCode;

  typedef struct packed {
    ErrCode      code;
    logic [63:0] order;
    logic [31:0] pc;
    logic [31:0] insn;
  } err_ctx_t;

  localparam logic [1:0] MODE_M  = 2'd3;
  localparam logic [1:0] IXL_RV32 = 2'd1;

endpackage

// File: rtl/rvfi_monitor_checker.sv
// Combinational invariant checks on one retirement; reports the lowest
// failing code. Validity gating is left to the caller.
module rvfi_monitor_checker
  import rvfi_monitor_pkg::*;
(
  input  MonState     state,
  input  logic [63:0] order,
  input  logic [63:0] last_order,
  input  logic [31:0] pc_rdata,
  input  logic [31:0] pc_wdata,
  input  logic [31:0] exp_pc,
  input  logic        pc_check_en,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] rd_wdata,
  input  logic [1:0]  mode,
  input  logic [1:0]  ixl,
  output ErrCode      code
);

  // Evaluated from highest to lowest code so the lowest failing one wins.
  always_comb begin
    code = NONE;
    if (state == HALTED)                      code = E_POSTHALT;
    if (mode != MODE_M || ixl != IXL_RV32)    code = E_MODE;
    if (pc_wdata[1:0] != 2'b00)               code = E_ALIGN;
    if (rd_addr == 5'd0 && rd_wdata != 32'd0) code = E_X0;
    if (pc_check_en && pc_rdata != exp_pc)    code = E_PC;
    if (state != IDLE && order <= last_order) code = E_ORDER;
  end

endmodule

// File: rtl/rvfi_trace_monitor.sv
// RVFI retirement-stream monitor: FSM, saturating retirement/trap counters
// and sticky first-failure context.
module rvfi_trace_monitor
  import rvfi_monitor_pkg::*;
#(
  parameter logic [31:0] ResetPc      = 32'h0000_0000,
  parameter logic        CheckStartPc = 1'b1,
  parameter int          CntWidth     = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic                rvfi_valid,
  input  logic                rvfi_trap,
  input  logic                rvfi_halt,
  input  logic                rvfi_intr,
  input  logic [63:0]         rvfi_order,
  input  logic [31:0]         rvfi_insn,
  input  logic [1:0]          rvfi_mode,
  input  logic [1:0]          rvfi_ixl,
  input  logic [4:0]          rvfi_rd_addr,
  input  logic [31:0]         rvfi_rd_wdata,
  input  logic [31:0]         rvfi_pc_rdata,
  input  logic [31:0]         rvfi_pc_wdata,
  output logic                err_o,
  output logic [2:0]          err_code_o,
  output logic [63:0]         err_order_o,
  output logic [31:0]         err_pc_o,
  output logic [31:0]         err_insn_o,
  output logic [CntWidth-1:0] retired_cnt_o,
  output logic [CntWidth-1:0] trap_cnt_o,
  output logic [1:0]          state_o,
  output logic                halted_o
);

  MonState             state_q, state_d;
  ErrCode              chk_code;
  err_ctx_t            ctx_q;
  logic                err_q;
  logic [63:0]         last_order_q;
  logic [31:0]         exp_pc_q;
  logic                pc_check_en_q;
  logic [CntWidth-1:0] ret_cnt_q, trap_cnt_q;
  logic                fail;
  logic                intr_unused;

  // Reserved for a future interrupt check.
  assign intr_unused = rvfi_intr;

  // The first retirement is compared against the reset vector instead.
  wire        first      = (state_q == IDLE);
  wire        pc_en_eff  = first ? CheckStartPc : pc_check_en_q;
  wire [31:0] exp_pc_eff = first ? ResetPc : exp_pc_q;

  rvfi_monitor_checker u_checker (
    .state       (state_q),
    .order       (rvfi_order),
    .last_order  (last_order_q),
    .pc_rdata    (rvfi_pc_rdata),
    .pc_wdata    (rvfi_pc_wdata),
    .exp_pc      (exp_pc_eff),
    .pc_check_en (pc_en_eff),
    .rd_addr     (rvfi_rd_addr),
    .rd_wdata    (rvfi_rd_wdata),
    .mode        (rvfi_mode),
    .ixl         (rvfi_ixl),
    .code        (chk_code)
  );

  assign fail = rvfi_valid && (chk_code != NONE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = IDLE;
    end else if (rvfi_valid) begin
      case (state_q)
        IDLE:    state_d = fail ? ERROR : RUN;
        RUN:     state_d = fail ? ERROR : (rvfi_halt ? HALTED : RUN);
        HALTED:  state_d = ERROR;
        default: state_d = ERROR;
      endcase
    end
  end

  always_comb begin
    state_o  = state_q;
    halted_o = (state_q == HALTED);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q         <= 1'b0;
      ctx_q         <= '0;
      last_order_q  <= '0;
      exp_pc_q      <= '0;
      pc_check_en_q <= 1'b0;
      ret_cnt_q     <= '0;
      trap_cnt_q    <= '0;
    end else if (clear_i) begin
      err_q         <= 1'b0;
      ctx_q         <= '0;
      last_order_q  <= '0;
      exp_pc_q      <= '0;
      pc_check_en_q <= 1'b0;
      ret_cnt_q     <= '0;
      trap_cnt_q    <= '0;
    end else begin
      if (rvfi_valid) begin
        last_order_q <= rvfi_order;
        exp_pc_q     <= rvfi_pc_wdata;
        if (ret_cnt_q != '1) ret_cnt_q <= ret_cnt_q + 1'b1;
      end
      if (rvfi_trap && trap_cnt_q != '1) trap_cnt_q <= trap_cnt_q + 1'b1;
      // A trap redirects the PC, so continuity is unknown until the next retirement.
      if (rvfi_trap)       pc_check_en_q <= 1'b0;
      else if (rvfi_valid) pc_check_en_q <= 1'b1;
      if (fail && !err_q) begin
        err_q <= 1'b1;
        ctx_q <= '{code: chk_code, order: rvfi_order, pc: rvfi_pc_rdata, insn: rvfi_insn};
      end
    end
  end

  assign err_o         = err_q;
  assign err_code_o    = ctx_q.code;
  assign err_order_o   = ctx_q.order;
  assign err_pc_o      = ctx_q.pc;
  assign err_insn_o    = ctx_q.insn;
  assign retired_cnt_o = ret_cnt_q;
  assign trap_cnt_o    = trap_cnt_q;

endmodule

// File: tb/tb_rvfi_trace_monitor.sv
// Directed bench for rvfi_trace_monitor; a second narrow-counter instance
// shares the stimulus for the saturation case.
module tb_rvfi_trace_monitor;

  logic        clk = 1'b0;
  logic        rst, clear;
  logic        valid, trap, halt, intr;
  logic [63:0] order;
  logic [31:0] insn, rd_wdata, pc_rdata, pc_wdata;
  logic [1:0]  mode, ixl;
  logic [4:0]  rd_addr;

  logic        err, halted;
  logic [2:0]  err_code;
  logic [63:0] err_order;
  logic [31:0] err_pc, err_insn, ret_cnt, trap_cnt;
  logic [1:0]  state;

  logic        err4, halted4;
  logic [2:0]  err_code4;
  logic [63:0] err_order4;
  logic [31:0] err_pc4, err_insn4;
  logic [3:0]  ret_cnt4, trap_cnt4;
  logic [1:0]  state4;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rvfi_trace_monitor #(.ResetPc(32'h0), .CheckStartPc(1'b1), .CntWidth(32)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear),
    .rvfi_valid(valid), .rvfi_trap(trap), .rvfi_halt(halt), .rvfi_intr(intr),
    .rvfi_order(order), .rvfi_insn(insn), .rvfi_mode(mode), .rvfi_ixl(ixl),
    .rvfi_rd_addr(rd_addr), .rvfi_rd_wdata(rd_wdata),
    .rvfi_pc_rdata(pc_rdata), .rvfi_pc_wdata(pc_wdata),
    .err_o(err), .err_code_o(err_code), .err_order_o(err_order),
    .err_pc_o(err_pc), .err_insn_o(err_insn),
    .retired_cnt_o(ret_cnt), .trap_cnt_o(trap_cnt),
    .state_o(state), .halted_o(halted)
  );

  rvfi_trace_monitor #(.ResetPc(32'h0), .CheckStartPc(1'b1), .CntWidth(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .clear_i(clear),
    .rvfi_valid(valid), .rvfi_trap(trap), .rvfi_halt(halt), .rvfi_intr(intr),
    .rvfi_order(order), .rvfi_insn(insn), .rvfi_mode(mode), .rvfi_ixl(ixl),
    .rvfi_rd_addr(rd_addr), .rvfi_rd_wdata(rd_wdata),
    .rvfi_pc_rdata(pc_rdata), .rvfi_pc_wdata(pc_wdata),
    .err_o(err4), .err_code_o(err_code4), .err_order_o(err_order4),
    .err_pc_o(err_pc4), .err_insn_o(err_insn4),
    .retired_cnt_o(ret_cnt4), .trap_cnt_o(trap_cnt4),
    .state_o(state4), .halted_o(halted4)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are read one falling edge later.
  task automatic ret(input logic [63:0] ord, input logic [31:0] pc, input logic [31:0] npc,
                     input logic hlt);
    valid = 1'b1; order = ord; pc_rdata = pc; pc_wdata = npc; halt = hlt;
    insn = 32'h0000_0013 | (pc << 7);
    @(negedge clk);
    valid = 1'b0; halt = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; valid = 1'b0; trap = 1'b0; halt = 1'b0; intr = 1'b0;
    order = '0; insn = '0; mode = 2'd3; ixl = 2'd1; rd_addr = 5'd1; rd_wdata = '0;
    pc_rdata = '0; pc_wdata = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_err", err, 0);
    chk("rst_code", err_code, 0);
    chk("rst_state", state, 0);
    chk("rst_ret", ret_cnt, 0);
    chk("rst_trap", trap_cnt, 0);
    rst = 1'b0;
    @(negedge clk);

    // Clean five-instruction stream
    for (int i = 0; i < 5; i++) ret(i, 4 * i, 4 * i + 4, 1'b0);
    chk("seq_ret", ret_cnt, 5);
    chk("seq_err", err, 0);
    chk("seq_state", state, 1);

    // PC discontinuity, then a later failure must not overwrite context
    do_clear();
    ret(0, 0, 4, 1'b0);
    ret(1, 8, 12, 1'b0);
    chk("pc_err", err, 1);
    chk("pc_code", err_code, 2);
    chk("pc_pc", err_pc, 8);
    chk("pc_order", err_order, 1);
    chk("pc_state", state, 3);
    ret(0, 32'h100, 32'h104, 1'b0);
    chk("pc_sticky_code", err_code, 2);
    chk("pc_sticky_pc", err_pc, 8);
    chk("pc_ret_in_err", ret_cnt, 3);

    // x0 write plus order regression: order wins
    do_clear();
    ret(0, 0, 4, 1'b0);
    rd_addr = 5'd0; rd_wdata = 32'd5;
    ret(0, 4, 8, 1'b0);
    rd_addr = 5'd1; rd_wdata = 32'd0;
    chk("prio_code", err_code, 1);

    // x0 write alone
    do_clear();
    ret(0, 0, 4, 1'b0);
    rd_addr = 5'd0; rd_wdata = 32'd5;
    ret(1, 4, 8, 1'b0);
    rd_addr = 5'd1; rd_wdata = 32'd0;
    chk("x0_code", err_code, 3);

    // Trap suspends the PC check for exactly one retirement
    do_clear();
    ret(0, 0, 4, 1'b0);
    trap = 1'b1;
    @(negedge clk);
    trap = 1'b0;
    ret(1, 32'h40, 32'h44, 1'b0);
    chk("trap_err", err, 0);
    chk("trap_cnt", trap_cnt, 1);
    chk("trap_ret", ret_cnt, 2);
    ret(2, 32'h50, 32'h54, 1'b0);
    chk("trap_rearm_code", err_code, 2);

    // Halt, post-halt retirement, then clear racing a retirement
    do_clear();
    ret(0, 0, 4, 1'b0);
    ret(1, 4, 8, 1'b1);
    chk("halt_halted", halted, 1);
    chk("halt_state", state, 2);
    chk("halt_err", err, 0);
    ret(2, 8, 12, 1'b0);
    chk("posthalt_code", err_code, 6);
    chk("posthalt_state", state, 3);
    clear = 1'b1;
    ret(3, 12, 16, 1'b0);
    clear = 1'b0;
    chk("clr_state", state, 0);
    chk("clr_err", err, 0);
    chk("clr_code", err_code, 0);
    chk("clr_ret", ret_cnt, 0);
    chk("clr_pc", err_pc, 0);
    chk("clr_halted", halted, 0);

    // First retirement against the reset vector, alignment, mode
    ret(0, 4, 8, 1'b0);
    chk("start_pc_code", err_code, 2);
    do_clear();
    ret(0, 0, 6, 1'b0);
    chk("align_code", err_code, 4);
    do_clear();
    mode = 2'd1;
    ret(0, 0, 4, 1'b0);
    mode = 2'd3;
    chk("mode_code", err_code, 5);
    do_clear();
    ixl = 2'd2;
    ret(0, 0, 4, 1'b0);
    ixl = 2'd1;
    chk("ixl_code", err_code, 5);

    // Mid-stream reset, then counter saturation on the 4-bit instance
    rst = 1'b1;
    @(negedge clk);
    chk("rst2_state", state, 0);
    chk("rst2_ret", ret_cnt, 0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) ret(i, 4 * i, 4 * i + 4, 1'b0);
    chk("sat_ret4", ret_cnt4, 15);
    chk("sat_ret32", ret_cnt, 20);
    chk("sat_err", err, 0);

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
